pll_div_chan: RTL

- One channel of the PLL feedback/output divider, placed directly downstream of the register block.
- Consumes a divide ratio byte and two enables per channel; produces a divided tick and a square output.
- Reports the active ratio back to the register block as a status byte with a one-cycle update strobe.
- Four instances, one per DCO channel.

---
 rtl/pll_div_pkg.sv | 15 +
 rtl/pll_div_cnt.sv | 48 ++++
 rtl/pll_div_chan.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pll_div_pkg.sv
// pll_div_pkg: shared definitions for the PLL divider channel.
//   state_t        : channel FSM state encoding
//   DIV_W_DEF      : default ratio/counter width
//   MIN_RATIO_DEF  : default smallest legal divide ratio
package pll_div_pkg;

  localparam int DIV_W_DEF     = 8;
  localparam int MIN_RATIO_DEF = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pll_div_cnt.sv
// pll_div_cnt: modulo-N counter with terminal-count and square-wave decode.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   run       : channel is in RUN; counting and decode enabled
//   clr       : force the counter back to 0 on the next edge
//   active    : current divide ratio N (>= 2 whenever run is high)
//   tc        : terminal count (cnt == N-1) while running
//   div_tick  : one-cycle pulse every N cycles (same as tc)
//   div_out   : high while cnt < N/2, low otherwise
module pll_div_cnt
  import pll_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic [DIV_W-1:0] active,
  output logic             tc,
  output logic             div_tick,
  output logic             div_out
);

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] last_s;
  logic [DIV_W-1:0] half_s;

  assign last_s = active - DIV_W'(1);
  assign half_s = active >> 1;

  // Decode from the registered count only; counter never exceeds active-1.
  assign tc       = run && (cnt_r == last_s);
  assign div_tick = tc;
  assign div_out  = run && (cnt_r < half_s);

  // Counter: 0..active-1 then wrap; held at 0 outside RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr || !run || tc) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/pll_div_chan.sv
// pll_div_chan: one channel of the PLL feedback/output divider.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   div_ratio   : requested divide ratio N
//   div_en_run  : level, 1 = divider running
//   div_en_upd  : rising edge requests a ratio reload while running
//   div_tick    : one-cycle pulse every N cycles
//   div_out     : divided square wave
//   dco_upd     : one-cycle strobe, a new ratio became active
//   dco_sts     : currently active ratio
//   load_err    : one-cycle strobe, requested ratio below MIN_RATIO ignored
module pll_div_chan
  import pll_div_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEF,
  parameter int MIN_RATIO = MIN_RATIO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             div_en_run,
  input  logic             div_en_upd,
  output logic             div_tick,
  output logic             div_out,
  output logic             dco_upd,
  output logic [DIV_W-1:0] dco_sts,
  output logic             load_err
);

  localparam logic [DIV_W-1:0] MIN_R = DIV_W'(MIN_RATIO);

  state_t           state_r, state_nxt;
  logic [DIV_W-1:0] active_r, active_nxt;
  logic [DIV_W-1:0] shadow_r, shadow_nxt;
  logic             pend_r, pend_nxt;
  logic             upd_q_r;
  logic             dco_upd_r, dco_upd_nxt;
  logic             load_err_r, load_err_nxt;

  logic             run_s;
  logic             clr_s;
  logic             tc_s;
  logic             ratio_ok_s;
  logic             upd_edge_s;

  assign run_s      = (state_r == RUN);
  assign clr_s      = run_s && !div_en_run;
  assign ratio_ok_s = (div_ratio >= MIN_R);
  assign upd_edge_s = div_en_upd && !upd_q_r;

  pll_div_cnt #(
    .DIV_W (DIV_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .run      (run_s),
    .clr      (clr_s),
    .active   (active_r),
    .tc       (tc_s),
    .div_tick (div_tick),
    .div_out  (div_out)
  );

  assign dco_upd  = dco_upd_r;
  assign load_err = load_err_r;
  assign dco_sts  = active_r;

  // Next-state, reload and status strobe logic.
  always_comb begin
    state_nxt    = state_r;
    active_nxt   = active_r;
    shadow_nxt   = shadow_r;
    pend_nxt     = pend_r;
    dco_upd_nxt  = 1'b0;
    load_err_nxt = 1'b0;
    case (state_r)
      IDLE: begin
        // A start always takes div_ratio directly; upd edges are ignored here.
        if (div_en_run) begin
          if (ratio_ok_s) begin
            state_nxt   = RUN;
            active_nxt  = div_ratio;
            dco_upd_nxt = 1'b1;
          end else begin
            load_err_nxt = 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (!div_en_run) begin
          // Stop wins over any pending or simultaneous reload.
          state_nxt = IDLE;
          pend_nxt  = 1'b0;
        end else begin
          if (tc_s && pend_r) begin
            active_nxt  = shadow_r;
            pend_nxt    = 1'b0;
            dco_upd_nxt = 1'b1;
          end else begin
            active_nxt = active_r;
          end
          // Assigned after the reload so a request landing on a terminal
          // count stays pending until the next one.
          if (upd_edge_s) begin
            if (ratio_ok_s) begin
              shadow_nxt = div_ratio;
              pend_nxt   = 1'b1;
            end else begin
              load_err_nxt = 1'b1;
            end
          end else begin
            shadow_nxt = shadow_r;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        pend_nxt  = 1'b0;
      end
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      active_r   <= '0;
      shadow_r   <= '0;
      pend_r     <= 1'b0;
      upd_q_r    <= 1'b0;
      dco_upd_r  <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      active_r   <= active_nxt;
      shadow_r   <= shadow_nxt;
      pend_r     <= pend_nxt;
      upd_q_r    <= div_en_upd;
      dco_upd_r  <= dco_upd_nxt;
      load_err_r <= load_err_nxt;
    end
  end

endmodule
